armleocpu_tlb: RTL and testbench
================================

Name: armleocpu_tlb

Overview:
Fully-associative Sv32 translation cache sitting directly upstream of the page table walker (PTW).
- The MMU front end issues a VPN lookup here first; on a miss it starts a PTW resolve.
- The PTW's completed leaf PTE is written back here.
- Supports 4 KiB pages and 4 MiB megapages, round-robin replacement, and whole-TLB invalidate for sfence.vma.

Parameters:
ENTRIES, 16, number of entries; power of two, 2..64
ENTRIES_W, $clog2(ENTRIES), width of the replacement pointer (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
async_rst_n  input  1  asynchronous active-low reset
resolve_request  input  1  lookup strobe, one cycle
resolve_vpn  input  20  virtual page number, vaddr[31:12]
resolve_done  output  1  lookup result valid, exactly one cycle after resolve_request
resolve_hit  output  1  hit qualifier, valid while resolve_done=1
resolve_ppn  output  22  translated physical page number
resolve_access_bits  output  8  PTE bits {D,A,G,U,X,W,R,V} of the matching entry
write_en  input  1  install entry (from PTW completion)
write_vpn  input  20  VPN of the installed translation
write_ppn  input  22  PTE PPN {PPN1[11:0],PPN0[9:0]}
write_megapage  input  1  entry is a level-1 leaf (4 MiB)
write_access_bits  input  8  PTE low byte
invalidate_all  input  1  clear every valid bit, one cycle

Behaviour:
- Reset (async assert):
  - all entry valid bits = 0; replacement pointer = 0.
  - resolve_done = 0, resolve_hit = 0, resolve_ppn = 0, resolve_access_bits = 0.
  - Tag/data arrays need no reset.
- Lookup latency is 1 cycle. The request is sampled at edge N; the result registers are visible after edge N and held until the next request.
  - resolve_done is high only in the cycle after the request.
  - resolve_hit/ppn/access_bits hold their last values when no request is made.
- Match rules:
  - 4 KiB entry matches when valid and tag[19:0] == resolve_vpn.
  - Megapage entry matches when valid and tag[19:10] == resolve_vpn[19:10].
- Output PPN:
  - 4 KiB hit: stored ppn.
  - Megapage hit: {stored ppn[21:10], resolve_vpn[9:0]}.
  - Miss: resolve_hit = 0; ppn and access_bits = 0.
- Multiple matches (software aliasing): the lowest-index matching entry wins. This is deterministic, not an error.
- Write:
  - If some valid entry already matches write_vpn (same match rule, same megapage flag), that entry is updated in place and the pointer does not move.
  - Otherwise the entry at the pointer is written with valid = 1, and the pointer increments, wrapping ENTRIES-1 -> 0.
  - write_access_bits[0] (V) = 0 is ignored: no install, no pointer move.
- Same-cycle interactions:
  - Lookup and write in the same cycle: the lookup sees pre-write state (read-before-write). A hit appears on the next lookup.
  - invalidate_all with write: invalidate wins and the write is dropped. The pointer resets to 0.
  - invalidate_all with lookup: the result is forced to a miss.
  - invalidate_all with no other event: all valid bits = 0 at the next edge; pointer = 0.
- Reset mid-lookup: resolve_done is cleared immediately; no pending result survives.
- No backpressure; one lookup per cycle sustained.

Decomposition:
- Shared package armleocpu_defines holds:
  - PTE access bit indices (V=0, R=1, W=2, X=3, U=4, G=5, A=6, D=7);
  - VPN_W = 20, PPN_W = 22, VPN1/VPN0 slice bounds.
- Natural sub-module armleocpu_tlb_way: one entry's tag/ppn/megapage/valid registers plus its match comparator.
  - The top instantiates ENTRIES ways via generate.
  - The top contains the priority encoder, output mux, pointer and write/invalidate control.

Test Plan:
- Reset, then lookup VPN 0x00001 -> next cycle resolve_done=1, resolve_hit=0, ppn=0.
- Write vpn=0x00001, ppn=0x000ABC, access=0xCF, megapage=0; lookup 0x00001 -> hit, ppn=0x000ABC, access=0xCF, done high exactly one cycle.
- Write megapage vpn=0x00400, ppn=0x001000, access=0x0F; lookup 0x007FF -> hit, ppn=0x0013FF; lookup 0x00800 -> miss.
- Replacement wrap: write ENTRIES+1 distinct 4 KiB VPNs 0x10..0x10+ENTRIES -> the first (0x10) misses, all others hit. Rewriting an existing VPN with new ppn updates in place without evicting.
- Write and lookup of the same VPN in one cycle -> miss. Lookup again the next cycle -> hit.
- invalidate_all with simultaneous write_en (vpn 0x00002) -> all prior entries miss, 0x00002 misses, and the next install lands in entry 0.

Source files
------------

// File: rtl/armleocpu_defines.sv
// Shared definitions for the Sv32 TLB slice.
// Holds PTE access-bit positions, VPN/PPN widths, the VPN1/VPN0 slice bounds
// and the tag comparison used for both lookups and installs.
package armleocpu_defines;

    localparam int VPN_W    = 20;
    localparam int PPN_W    = 22;
    localparam int ACCESS_W = 8;

    // VPN1 selects the 4 MiB megapage, VPN0 the 4 KiB page inside it.
    localparam int VPN1_HI = 19;
    localparam int VPN1_LO = 10;
    localparam int VPN0_HI = 9;
    localparam int VPN0_LO = 0;

    // PTE low-byte bit positions.
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    // A megapage tag only compares VPN1; a 4 KiB tag compares the full VPN.
    function automatic logic vpn_match(input logic [VPN_W-1:0] tag,
                                       input logic [VPN_W-1:0] vpn,
                                       input logic             megapage);
        if (megapage)
            return tag[VPN1_HI:VPN1_LO] == vpn[VPN1_HI:VPN1_LO];
        else
            return tag == vpn;
    endfunction

endpackage

// File: rtl/armleocpu_tlb_way.sv
// One TLB entry: valid bit, tag, PPN, megapage flag and access bits, plus the
// comparators used by the lookup path and by the install path.
// Ports:
//   clk, async_rst_n      clock, async active-low reset (clears valid only)
//   invalidate            clear valid at the next edge (wins over write_en)
//   write_en              load this entry with write_* and set valid
//   write_*               translation being installed
//   lookup_vpn            VPN under lookup
//   lookup_match          entry is valid and covers lookup_vpn
//   write_match           entry is valid, same page size, and covers write_vpn
//   ppn/megapage/access_bits  stored contents
module armleocpu_tlb_way
    import armleocpu_defines::*;
(
    input  logic                clk,
    input  logic                async_rst_n,
    input  logic                invalidate,
    input  logic                write_en,
    input  logic [VPN_W-1:0]    write_vpn,
    input  logic [PPN_W-1:0]    write_ppn,
    input  logic                write_megapage,
    input  logic [ACCESS_W-1:0] write_access_bits,
    input  logic [VPN_W-1:0]    lookup_vpn,
    output logic                lookup_match,
    output logic                write_match,
    output logic [PPN_W-1:0]    ppn,
    output logic                megapage,
    output logic [ACCESS_W-1:0] access_bits
);

    logic                valid_q, valid_d;
    logic [VPN_W-1:0]    tag_q;
    logic [PPN_W-1:0]    ppn_q;
    logic                megapage_q;
    logic [ACCESS_W-1:0] access_bits_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        valid_d = valid_q;
        if (invalidate)
            valid_d = 1'b0;
        else if (write_en)
            valid_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)
            valid_q <= 1'b0;
        else
            valid_q <= valid_d;
    end

    // NOTE: payload registers are not reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (write_en && !invalidate) begin
            tag_q         <= write_vpn;
            ppn_q         <= write_ppn;
            megapage_q    <= write_megapage;
            access_bits_q <= write_access_bits;
        end
    end

    assign lookup_match = valid_q && vpn_match(tag_q, lookup_vpn, megapage_q);
    assign write_match  = valid_q && (megapage_q == write_megapage)
                          && vpn_match(tag_q, write_vpn, megapage_q);
    assign ppn          = ppn_q;
    assign megapage     = megapage_q;
    assign access_bits  = access_bits_q;

endmodule

// File: rtl/armleocpu_tlb.sv
// Fully-associative Sv32 TLB in front of the page table walker.
// Ports:
//   clk, async_rst_n                 clock, async active-low reset
//   resolve_request / resolve_vpn    one-cycle lookup strobe and VPN
//   resolve_done                     high for exactly one cycle after a request
//   resolve_hit/ppn/access_bits      registered result, held between requests
//   write_en / write_*               install a leaf PTE from the walker
//   invalidate_all                   clear every entry (sfence.vma)
// Lookups read pre-write state; installs update a matching entry in place or
// replace the round-robin victim; lowest index wins on aliased matches.
module armleocpu_tlb
    import armleocpu_defines::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic                clk,
    input  logic                async_rst_n,
    input  logic                resolve_request,
    input  logic [VPN_W-1:0]    resolve_vpn,
    output logic                resolve_done,
    output logic                resolve_hit,
    output logic [PPN_W-1:0]    resolve_ppn,
    output logic [ACCESS_W-1:0] resolve_access_bits,
    input  logic                write_en,
    input  logic [VPN_W-1:0]    write_vpn,
    input  logic [PPN_W-1:0]    write_ppn,
    input  logic                write_megapage,
    input  logic [ACCESS_W-1:0] write_access_bits,
    input  logic                invalidate_all
);

    localparam int ENTRIES_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0]  lookup_match, write_match, way_we;
    logic [PPN_W-1:0]    way_ppn         [ENTRIES];
    logic                way_megapage    [ENTRIES];
    logic [ACCESS_W-1:0] way_access_bits [ENTRIES];

    for (genvar g = 0; g < ENTRIES; g++) begin : g_way
        armleocpu_tlb_way u_way (
            .clk               (clk),
            .async_rst_n       (async_rst_n),
            .invalidate        (invalidate_all),
            .write_en          (way_we[g]),
            .write_vpn         (write_vpn),
            .write_ppn         (write_ppn),
            .write_megapage    (write_megapage),
            .write_access_bits (write_access_bits),
            .lookup_vpn        (resolve_vpn),
            .lookup_match      (lookup_match[g]),
            .write_match       (write_match[g]),
            .ppn               (way_ppn[g]),
            .megapage          (way_megapage[g]),
            .access_bits       (way_access_bits[g])
        );
    end

    // Lowest-index priority encoders: scanning downward leaves the lowest match.
    logic                 hit_any, wr_any;
    logic [ENTRIES_W-1:0] hit_idx, wr_idx;

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        wr_any  = 1'b0;
        wr_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (lookup_match[i]) begin
                hit_any = 1'b1;
                hit_idx = ENTRIES_W'(i);
            end
            if (write_match[i]) begin
                wr_any = 1'b1;
                wr_idx = ENTRIES_W'(i);
            end
        end
    end

    // Install control: a PTE with V=0 is not a translation and is dropped.
    logic                 install;
    logic [ENTRIES_W-1:0] ptr_q, ptr_d;

    assign install = write_en && write_access_bits[PTE_V] && !invalidate_all;

    always_comb begin
        way_we = '0;
        ptr_d  = ptr_q;
        if (invalidate_all) begin
            ptr_d = '0;
        end else if (install) begin
            if (wr_any) begin
                way_we[wr_idx] = 1'b1;
            end else begin
                way_we[ptr_q] = 1'b1;
                ptr_d         = ptr_q + ENTRIES_W'(1);  // power-of-two wrap
            end
        end
    end

    // Result registers.
    logic                resolve_done_q, resolve_done_d;
    logic                resolve_hit_q, resolve_hit_d;
    logic [PPN_W-1:0]    resolve_ppn_q, resolve_ppn_d;
    logic [ACCESS_W-1:0] resolve_access_bits_q, resolve_access_bits_d;

    always_comb begin
        resolve_done_d        = resolve_request;
        resolve_hit_d         = resolve_hit_q;
        resolve_ppn_d         = resolve_ppn_q;
        resolve_access_bits_d = resolve_access_bits_q;
        if (resolve_request) begin
            if (hit_any && !invalidate_all) begin
                resolve_hit_d         = 1'b1;
                resolve_access_bits_d = way_access_bits[hit_idx];
                if (way_megapage[hit_idx])
                    resolve_ppn_d = {way_ppn[hit_idx][PPN_W-1:VPN1_LO],
                                     resolve_vpn[VPN0_HI:VPN0_LO]};
                else
                    resolve_ppn_d = way_ppn[hit_idx];
            end else begin
                resolve_hit_d         = 1'b0;
                resolve_ppn_d         = '0;
                resolve_access_bits_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            ptr_q                 <= '0;
            resolve_done_q        <= 1'b0;
            resolve_hit_q         <= 1'b0;
            resolve_ppn_q         <= '0;
            resolve_access_bits_q <= '0;
        end else begin
            ptr_q                 <= ptr_d;
            resolve_done_q        <= resolve_done_d;
            resolve_hit_q         <= resolve_hit_d;
            resolve_ppn_q         <= resolve_ppn_d;
            resolve_access_bits_q <= resolve_access_bits_d;
        end
    end

    assign resolve_done        = resolve_done_q;
    assign resolve_hit         = resolve_hit_q;
    assign resolve_ppn         = resolve_ppn_q;
    assign resolve_access_bits = resolve_access_bits_q;

endmodule

// File: tb/tb_armleocpu_tlb.sv
// Directed bench for armleocpu_tlb: reset values, 4 KiB and megapage hits,
// V=0 drop, round-robin wrap, in-place update, read-before-write,
// invalidate interactions, aliasing priority and reset during a result.
module tb_armleocpu_tlb;
    import armleocpu_defines::*;

    localparam int ENTRIES = 16;

    logic                clk = 1'b0;
    logic                async_rst_n = 1'b0;
    logic                resolve_request = 1'b0;
    logic [VPN_W-1:0]    resolve_vpn = '0;
    logic                resolve_done;
    logic                resolve_hit;
    logic [PPN_W-1:0]    resolve_ppn;
    logic [ACCESS_W-1:0] resolve_access_bits;
    logic                write_en = 1'b0;
    logic [VPN_W-1:0]    write_vpn = '0;
    logic [PPN_W-1:0]    write_ppn = '0;
    logic                write_megapage = 1'b0;
    logic [ACCESS_W-1:0] write_access_bits = '0;
    logic                invalidate_all = 1'b0;

    int checks = 0;
    int errors = 0;

    armleocpu_tlb #(.ENTRIES(ENTRIES)) dut (
        .clk                 (clk),
        .async_rst_n         (async_rst_n),
        .resolve_request     (resolve_request),
        .resolve_vpn         (resolve_vpn),
        .resolve_done        (resolve_done),
        .resolve_hit         (resolve_hit),
        .resolve_ppn         (resolve_ppn),
        .resolve_access_bits (resolve_access_bits),
        .write_en            (write_en),
        .write_vpn           (write_vpn),
        .write_ppn           (write_ppn),
        .write_megapage      (write_megapage),
        .write_access_bits   (write_access_bits),
        .invalidate_all      (invalidate_all)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then drop all strobes; outputs are read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        resolve_request = 1'b0;
        write_en        = 1'b0;
        invalidate_all  = 1'b0;
    endtask

    task automatic set_write(input logic [19:0] vpn, input logic [21:0] ppn,
                             input logic mega, input logic [7:0] acc);
        write_en          = 1'b1;
        write_vpn         = vpn;
        write_ppn         = ppn;
        write_megapage    = mega;
        write_access_bits = acc;
    endtask

    task automatic install(input logic [19:0] vpn, input logic [21:0] ppn,
                           input logic mega, input logic [7:0] acc);
        set_write(vpn, ppn, mega, acc);
        step();
    endtask

    task automatic expect_result(input string tag, input logic hit,
                                 input logic [21:0] ppn, input logic [7:0] acc);
        check({tag, ".done"}, 32'(resolve_done), 32'd1);
        check({tag, ".hit"},  32'(resolve_hit), 32'(hit));
        check({tag, ".ppn"},  32'(resolve_ppn), 32'(ppn));
        check({tag, ".acc"},  32'(resolve_access_bits), 32'(acc));
    endtask

    task automatic lookup(input string tag, input logic [19:0] vpn, input logic hit,
                          input logic [21:0] ppn, input logic [7:0] acc);
        resolve_request = 1'b1;
        resolve_vpn     = vpn;
        step();
        expect_result(tag, hit, ppn, acc);
    endtask

    initial begin
        // Reset state while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst.done", 32'(resolve_done), 32'd0);
        check("rst.hit",  32'(resolve_hit), 32'd0);
        check("rst.ppn",  32'(resolve_ppn), 32'd0);
        check("rst.acc",  32'(resolve_access_bits), 32'd0);
        check("rst.ptr",  32'(dut.ptr_q), 32'd0);
        async_rst_n = 1'b1;
        step();

        // Empty TLB misses.
        lookup("empty", 20'h00001, 1'b0, 22'h0, 8'h00);

        // 4 KiB install and hit; done lasts one cycle and the result holds.
        install(20'h00001, 22'h000ABC, 1'b0, 8'hCF);
        lookup("4k", 20'h00001, 1'b1, 22'h000ABC, 8'hCF);
        step();
        check("4k.done_drop", 32'(resolve_done), 32'd0);
        check("4k.hit_hold",  32'(resolve_hit), 32'd1);
        check("4k.ppn_hold",  32'(resolve_ppn), 32'h000ABC);

        // Megapage: PPN0 comes from the lookup VPN; next megapage is a miss.
        install(20'h00400, 22'h001000, 1'b1, 8'h0F);
        lookup("mega_top", 20'h007FF, 1'b1, 22'h0013FF, 8'h0F);
        lookup("mega_base", 20'h00400, 1'b1, 22'h001000, 8'h0F);
        lookup("mega_out", 20'h00800, 1'b0, 22'h0, 8'h00);

        // A PTE with V=0 is not installed.
        install(20'h00005, 22'h000555, 1'b0, 8'h0E);
        lookup("v0_drop", 20'h00005, 1'b0, 22'h0, 8'h00);

        // ENTRIES+1 distinct installs: only the first one is evicted.
        for (int i = 0; i <= ENTRIES; i++)
            install(20'(32'h10 + i), 22'(32'h100 + i), 1'b0, 8'hC7);
        lookup("wrap_evict", 20'h00010, 1'b0, 22'h0, 8'h00);
        for (int i = 1; i <= ENTRIES; i++)
            lookup($sformatf("wrap_%0d", i), 20'(32'h10 + i), 1'b1, 22'(32'h100 + i), 8'hC7);

        // Rewriting a resident VPN updates in place; the victim slot survives.
        install(20'h00015, 22'h0003AA, 1'b0, 8'hC3);
        lookup("upd_new", 20'h00015, 1'b1, 22'h0003AA, 8'hC3);
        lookup("upd_keep", 20'h00011, 1'b1, 22'h000101, 8'hC7);
        lookup("upd_last", 20'h00020, 1'b1, 22'h000110, 8'hC7);

        // Lookup and write of the same VPN in one cycle sees pre-write state.
        set_write(20'h00003, 22'h000033, 1'b0, 8'hC7);
        lookup("rbw_same", 20'h00003, 1'b0, 22'h0, 8'h00);
        lookup("rbw_next", 20'h00003, 1'b1, 22'h000033, 8'hC7);

        // Invalidate with a lookup forces a miss and clears everything.
        invalidate_all = 1'b1;
        lookup("inv_lookup", 20'h00003, 1'b0, 22'h0, 8'h00);
        lookup("inv_after", 20'h00011, 1'b0, 22'h0, 8'h00);

        // Invalidate wins over a simultaneous write and resets the pointer.
        install(20'h00030, 22'h000030, 1'b0, 8'hC7);
        set_write(20'h00002, 22'h000022, 1'b0, 8'hC7);
        invalidate_all = 1'b1;
        step();
        check("invw.ptr", 32'(dut.ptr_q), 32'd0);
        lookup("invw_old", 20'h00030, 1'b0, 22'h0, 8'h00);
        lookup("invw_drop", 20'h00002, 1'b0, 22'h0, 8'h00);

        // Next installs land in entries 0 and 1; the aliased megapage (entry 0) wins.
        install(20'h00400, 22'h002000, 1'b1, 8'h0F);
        install(20'h00401, 22'h000111, 1'b0, 8'hC7);
        check("alias.ptr", 32'(dut.ptr_q), 32'd2);
        lookup("alias_hit", 20'h00401, 1'b1, 22'h002001, 8'h0F);

        // Reset asserted while a result is showing clears it immediately.
        resolve_request = 1'b1;
        resolve_vpn     = 20'h00401;
        step();
        check("mid.done_before", 32'(resolve_done), 32'd1);
        async_rst_n = 1'b0;
        #1;
        check("mid.done", 32'(resolve_done), 32'd0);
        check("mid.hit",  32'(resolve_hit), 32'd0);
        check("mid.ppn",  32'(resolve_ppn), 32'd0);
        async_rst_n = 1'b1;
        step();
        lookup("post_rst", 20'h00401, 1'b0, 22'h0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
